// File: rtl/zeroriscy_csr_arbiter.sv
// Arbitrates the single CSR file port between the ID stage and the debug unit.
// One registered command per access: grant -> issue -> response, with trap sequencing taking precedence.
module zeroriscy_csr_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        core_req_i,
    input  logic [11:0] core_addr_i,
    input  logic [31:0] core_wdata_i,
    input  logic [1:0]  core_op_i,
    output logic        core_gnt_o,
    output logic        core_rvalid_o,
    output logic [31:0] core_rdata_o,
    input  logic        dbg_req_i,
    input  logic        dbg_we_i,
    input  logic [11:0] dbg_addr_i,
    input  logic [31:0] dbg_wdata_i,
    output logic        dbg_gnt_o,
    output logic        dbg_rvalid_o,
    output logic [31:0] dbg_rdata_o,
    input  logic        trap_busy_i,
    output logic        csr_access_o,
    output logic [11:0] csr_addr_o,
    output logic [31:0] csr_wdata_o,
    output logic [1:0]  csr_op_o,
    input  logic [31:0] csr_rdata_i
);

    localparam int unsigned CW = $clog2(STARVE_LIMIT + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        OP_NONE  = 2'b00,
        OP_WRITE = 2'b01,
        OP_SET   = 2'b10,
        OP_CLEAR = 2'b11
    } csr_op_e;

    state_e        state_q, state_d;
    logic [CW-1:0] starve_cnt_q, starve_cnt_d;
    logic          owner_q, owner_d;   // 0: core, 1: debug
    logic [11:0]   addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [1:0]    op_q, op_d;
    logic [31:0]   rdata_q, rdata_d;

    logic can_grant;
    logic dbg_wins;
    logic issue;

    always_comb begin
        state_d       = state_q;
        owner_d       = owner_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        op_d          = op_q;
        rdata_d       = rdata_q;
        starve_cnt_d  = starve_cnt_q;
        core_gnt_o    = 1'b0;
        dbg_gnt_o     = 1'b0;
        issue         = 1'b0;

        can_grant = (state_q == IDLE) && !trap_busy_i && !rst;
        dbg_wins  = dbg_req_i && (!core_req_i || (starve_cnt_q == CW'(STARVE_LIMIT)));

        unique case (state_q)
            IDLE: begin
                if (can_grant && (core_req_i || dbg_req_i)) begin
                    state_d = ISSUE;
                    if (dbg_wins) begin
                        dbg_gnt_o = 1'b1;
                        owner_d   = 1'b1;
                        addr_d    = dbg_addr_i;
                        wdata_d   = dbg_wdata_i;
                        op_d      = dbg_we_i ? OP_WRITE : OP_NONE;
                    end else begin
                        core_gnt_o = 1'b1;
                        owner_d    = 1'b0;
                        addr_d     = core_addr_i;
                        wdata_d    = core_wdata_i;
                        op_d       = core_op_i;
                    end
                end
            end
            ISSUE: begin
                if (!trap_busy_i) begin
                    issue   = 1'b1;
                    rdata_d = csr_rdata_i;
                    state_d = RESP;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Counter tracks a continuously held debug request; any gap or a grant restarts it.
        if (!dbg_req_i || dbg_gnt_o) begin
            starve_cnt_d = '0;
        end else if (starve_cnt_q != CW'(STARVE_LIMIT)) begin
            starve_cnt_d = starve_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            starve_cnt_q <= '0;
            owner_q      <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            op_q         <= OP_NONE;
            rdata_q      <= '0;
        end else begin
            state_q      <= state_d;
            starve_cnt_q <= starve_cnt_d;
            owner_q      <= owner_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            op_q         <= op_d;
            rdata_q      <= rdata_d;
        end
    end

    // The CSR file writes on op, so op is forced to NONE whenever no access is issued.
    assign csr_access_o  = issue && !rst;
    assign csr_op_o      = csr_access_o ? op_q : OP_NONE;
    assign csr_addr_o    = addr_q;
    assign csr_wdata_o   = wdata_q;

    assign core_rvalid_o = (state_q == RESP) && !owner_q && !rst;
    assign dbg_rvalid_o  = (state_q == RESP) &&  owner_q && !rst;
    assign core_rdata_o  = core_rvalid_o ? rdata_q : '0;
    assign dbg_rdata_o   = dbg_rvalid_o  ? rdata_q : '0;

endmodule

// File: doc/zeroriscy_csr_arbiter.md
Name: zeroriscy_csr_arbiter

Overview:
- Shares the single CSR register-file access port between two requesters: the core ID stage and the debug unit.
- Accepts one request at a time through a req/gnt handshake and registers the command.
- Issues the command to the CSR file for one cycle and returns the read data with a registered rvalid.
- Lets trap save/restore sequencing (exception entry, MRET) pre-empt all arbitrated accesses. Sits between the ID stage / debug unit and zeroriscy_cs_registers.

Parameters:
STARVE_LIMIT, 4, consecutive denied debug-request cycles after which debug wins over core (must be >= 1)

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
core_req_i  input  1  core CSR request
core_addr_i  input  12  core CSR address
core_wdata_i  input  32  core write operand
core_op_i  input  2  core CSR op (NONE=00, WRITE=01, SET=10, CLEAR=11)
core_gnt_o  output  1  core request accepted this cycle
core_rvalid_o  output  1  core read data valid
core_rdata_o  output  32  core read data
dbg_req_i  input  1  debug CSR request
dbg_we_i  input  1  debug write (1) / read (0)
dbg_addr_i  input  12  debug CSR address
dbg_wdata_i  input  32  debug write data
dbg_gnt_o  output  1  debug request accepted this cycle
dbg_rvalid_o  output  1  debug read data valid
dbg_rdata_o  output  32  debug read data
trap_busy_i  input  1  csr_save_cause or csr_restore_mret active this cycle
csr_access_o  output  1  CSR port access qualifier
csr_addr_o  output  12  CSR address
csr_wdata_o  output  32  CSR write data
csr_op_o  output  2  CSR op
csr_rdata_i  input  32  CSR read data (combinational from CSR file)

Behaviour:
- Clock and reset: single clock clk. Reset rst is synchronous, active-high.
- Reset values:
  - State is IDLE; starvation counter is 0; command registers are 0.
  - All gnt, rvalid and csr_access outputs are 0; csr_op_o is NONE; rdata outputs are 0.
- FSM states: IDLE, ISSUE, RESP.
- IDLE:
  - No grant while trap_busy_i=1.
  - Otherwise, if any request is present, grant exactly one requester (gnt is a combinational 1-cycle pulse).
  - On grant, latch owner, addr, wdata and op, then go to ISSUE.
- Grant priority:
  - Core wins by default.
  - Debug wins if only debug requests, or if starve_cnt == STARVE_LIMIT.
- Debug op mapping: dbg_we_i=1 maps to WRITE; dbg_we_i=0 maps to NONE (read only).
- Core op: passed unchanged. Core NONE is a pure read.
- ISSUE with trap_busy_i=0:
  - Drive csr_access_o=1 and addr/wdata/op from the command registers.
  - Capture csr_rdata_i into the response register; go to RESP.
- ISSUE with trap_busy_i=1:
  - Stall in ISSUE with csr_access_o=0 and csr_op_o=NONE. No CSR write occurs.
  - Issue in the first cycle trap_busy_i is 0.
- RESP: assert rvalid for the owner only, for exactly 1 cycle, with rdata held stable. Go to IDLE. No grant in RESP.
- Latency: grant in cycle N, access in N+1, rvalid in N+2 (plus stall cycles). Throughput is 1 access per 3 cycles.
- Port defaults outside the issuing cycle:
  - csr_access_o=0 and csr_op_o=NONE (the CSR file writes on op).
  - csr_addr_o and csr_wdata_o hold the last command value.
- Non-owner outputs: rdata_o is 0 when rvalid_o=0.
- Starvation counter:
  - Increments in every cycle where dbg_req_i=1 and the debug request is not granted (including non-IDLE cycles).
  - Saturates at STARVE_LIMIT.
  - Clears when debug is granted or when dbg_req_i=0.
  - Width is clog2(STARVE_LIMIT+1).
- Simultaneous requests:
  - Only one gnt per cycle.
  - The losing request must be held by its requester; the arbiter stores nothing for it.
- Reset mid-operation: any pending command is dropped, no rvalid is produced, and the FSM returns to IDLE next cycle.
- Requests dropped before grant are ignored without side effects.

Test Plan:
- Single core read: core_req=1, addr=0x341, op=NONE, csr_rdata_i=0x0000_1234.
  - core_gnt at N; csr_access=1 with op=00 at N+1; core_rvalid=1 with rdata=0x1234 at N+2. dbg outputs stay 0.
- Debug write: dbg_req=1, we=1, addr=0x300, wdata=0x8.
  - dbg_gnt at N; at N+1 csr_op=01, addr=0x300, wdata=0x8; dbg_rvalid at N+2.
- Starvation with STARVE_LIMIT=4: core_req and dbg_req held continuously.
  - Core wins the first grant; debug wins once starve_cnt reaches 4.
  - starve_cnt clears on the debug grant; the next grant goes to core.
- Trap pre-emption: core SET granted at N, trap_busy=1 for cycles N+1..N+3.
  - csr_access=0 and op=00 during N+1..N+3; access at N+4; rvalid at N+5.
  - trap_busy=1 in IDLE produces no gnt.
- Reset mid-op: grant at N, rst=1 at N+1.
  - At N+2: state IDLE, csr_access=0, no rvalid, starve_cnt=0.
- Back-to-back core requests with core_req held high:
  - Grants at N, N+3, N+6. There is never more than one rvalid per access, and csr_op is NONE in every non-issue cycle.
